framebuffer_reader_stream: RTL and testbench

FRAMEBUFFER_READER_STREAM -- requirements
Module: framebuffer_reader_stream

---
 rtl/framebuffer_reader_stream.sv | 158 +++++++++++++++
 tb/tb_framebuffer_reader_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_reader_stream.sv
// Framebuffer reader: issues one read request per pixel of a frame in raster
// order and forwards the in-order read responses as a pixel stream tagged
// with x/y position and an end-of-frame marker.
module framebuffer_reader_stream #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned X_BIT_WIDTH     = 11,
  parameter int unsigned Y_BIT_WIDTH     = 11,
  parameter int unsigned PIXEL_WIDTH     = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic [ADDR_WIDTH-1:0]  confBaseAddr,
  input  logic [X_BIT_WIDTH-1:0] confXResolution,
  input  logic [Y_BIT_WIDTH-1:0] confYResolution,
  input  logic                   apply,
  output logic                   applied,
  output logic                   m_req_tvalid,
  input  logic                   m_req_tready,
  output logic [ADDR_WIDTH-1:0]  m_req_taddr,
  input  logic                   s_rsp_tvalid,
  output logic                   s_rsp_tready,
  input  logic [PIXEL_WIDTH-1:0] s_rsp_tdata,
  output logic                   m_frag_tvalid,
  input  logic                   m_frag_tready,
  output logic [PIXEL_WIDTH-1:0] m_frag_tdata,
  output logic                   m_frag_tlast,
  output logic [X_BIT_WIDTH-1:0] m_frag_txpos,
  output logic [Y_BIT_WIDTH-1:0] m_frag_typos
);

  localparam int unsigned PixBytes = PIXEL_WIDTH / 8;
  localparam int unsigned CntW     = X_BIT_WIDTH + Y_BIT_WIDTH;
  localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [X_BIT_WIDTH-1:0] xres_q, xres_d;
  logic [Y_BIT_WIDTH-1:0] yres_q, yres_d;
  logic [X_BIT_WIDTH-1:0] xpos_q, xpos_d;
  logic [Y_BIT_WIDTH-1:0] ypos_q, ypos_d;
  logic [CntW-1:0]        req_left_q, req_left_d;
  logic [OutW-1:0]        outst_q, outst_d;

  logic busy;
  logic req_hs;
  logic frag_hs;
  logic x_wrap;
  logic last_pix;

  assign busy    = (state_q == StRead);
  assign applied = ~busy;

  // Valid only drops via a request handshake: outstanding can only shrink and
  // the remaining count only changes on handshake, so valid/addr hold under stall.
  assign m_req_tvalid = busy && (req_left_q != '0) && (outst_q < OutW'(MAX_OUTSTANDING));
  assign m_req_taddr  = addr_q;

  // Zero-latency response pass-through, gated off while idle.
  assign m_frag_tvalid = busy & s_rsp_tvalid;
  assign s_rsp_tready  = busy & m_frag_tready;
  assign m_frag_tdata  = s_rsp_tdata;

  assign req_hs  = m_req_tvalid & m_req_tready;
  assign frag_hs = m_frag_tvalid & m_frag_tready;

  assign x_wrap   = (xpos_q == xres_q - X_BIT_WIDTH'(1));
  assign last_pix = busy && x_wrap && (ypos_q == yres_q - Y_BIT_WIDTH'(1));

  assign m_frag_tlast = last_pix;
  assign m_frag_txpos = xpos_q;
  assign m_frag_typos = ypos_q;

  // Next-state logic for the frame FSM, request side and output position.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    xres_d     = xres_q;
    yres_d     = yres_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    req_left_d = req_left_q;
    outst_d    = outst_q;

    unique case (state_q)
      StIdle: begin
        if (apply) begin
          addr_d     = confBaseAddr;
          xres_d     = confXResolution;
          yres_d     = confYResolution;
          xpos_d     = '0;
          ypos_d     = '0;
          outst_d    = '0;
          req_left_d = CntW'(confXResolution) * CntW'(confYResolution);
          // An empty frame is a no-op: stay idle.
          if ((confXResolution != '0) && (confYResolution != '0)) begin
            state_d = StRead;
          end
        end
      end

      StRead: begin
        if (req_hs) begin
          addr_d     = addr_q + ADDR_WIDTH'(PixBytes);
          req_left_d = req_left_q - CntW'(1);
        end

        if (req_hs && !frag_hs) begin
          outst_d = outst_q + OutW'(1);
        end else if (!req_hs && frag_hs && (outst_q != '0)) begin
          outst_d = outst_q - OutW'(1);
        end

        if (frag_hs) begin
          if (x_wrap) begin
            xpos_d = '0;
            ypos_d = ypos_q + Y_BIT_WIDTH'(1);
          end else begin
            xpos_d = xpos_q + X_BIT_WIDTH'(1);
          end
          if (last_pix) begin
            state_d = StIdle;
            xpos_d  = '0;
            ypos_d  = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers; reset forces idle with all counters and address cleared.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      xres_q     <= '0;
      yres_q     <= '0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      req_left_q <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      xres_q     <= xres_d;
      yres_q     <= yres_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      req_left_q <= req_left_d;
      outst_q    <= outst_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_reader_stream.sv
// Scoreboard bench for framebuffer_reader_stream: expected addresses and
// pixels are queued when a frame is applied and popped on each handshake.
module tb_framebuffer_reader_stream;

  localparam int AW = 32;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int PW = 16;
  localparam int MO = 8;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] confBaseAddr = '0;
  logic [XW-1:0] confXResolution = '0;
  logic [YW-1:0] confYResolution = '0;
  logic          apply = 1'b0;
  logic          applied;
  logic          m_req_tvalid;
  logic          m_req_tready = 1'b0;
  logic [AW-1:0] m_req_taddr;
  logic          s_rsp_tvalid = 1'b0;
  logic          s_rsp_tready;
  logic [PW-1:0] s_rsp_tdata = '0;
  logic          m_frag_tvalid;
  logic          m_frag_tready = 1'b0;
  logic [PW-1:0] m_frag_tdata;
  logic          m_frag_tlast;
  logic [XW-1:0] m_frag_txpos;
  logic [YW-1:0] m_frag_typos;

  framebuffer_reader_stream #(
    .ADDR_WIDTH(AW), .X_BIT_WIDTH(XW), .Y_BIT_WIDTH(YW),
    .PIXEL_WIDTH(PW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .confBaseAddr(confBaseAddr), .confXResolution(confXResolution),
    .confYResolution(confYResolution), .apply(apply), .applied(applied),
    .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready), .m_req_taddr(m_req_taddr),
    .s_rsp_tvalid(s_rsp_tvalid), .s_rsp_tready(s_rsp_tready), .s_rsp_tdata(s_rsp_tdata),
    .m_frag_tvalid(m_frag_tvalid), .m_frag_tready(m_frag_tready),
    .m_frag_tdata(m_frag_tdata), .m_frag_tlast(m_frag_tlast),
    .m_frag_txpos(m_frag_txpos), .m_frag_typos(m_frag_typos)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } pix_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  pix_t          sb_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] rsp_q[$];
  bit            stall_req = 0, stall_frag = 0, hold_rsp = 0, apply_pend = 0;
  int            rsp_credit = 0;
  int            req_seen = 0, pix_seen = 0;
  bit            prev_stalled = 0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [PW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = (a >> 1) * 32'd40503;
    return h[PW-1:0] ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, then observe the handshakes that the
  // next posedge will commit.
  task automatic step();
    pix_t e;
    @(negedge aclk);
    apply      = apply_pend;
    apply_pend = 0;
    m_req_tready  = stall_req  ? ($urandom_range(0, 2) != 0) : 1'b1;
    m_frag_tready = stall_frag ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (rsp_q.size() > 0 && (!hold_rsp || rsp_credit > 0) &&
        (!stall_frag || $urandom_range(0, 3) != 0)) begin
      s_rsp_tvalid = 1'b1;
      s_rsp_tdata  = mem_rd(rsp_q[0]);
    end else begin
      s_rsp_tvalid = 1'b0;
      s_rsp_tdata  = PW'($urandom);
    end
    #1;
    if (prev_stalled) begin
      check("req_hold_valid", m_req_tvalid, 1'b1);
      check("req_hold_addr", m_req_taddr, prev_addr);
    end
    prev_stalled = m_req_tvalid && !m_req_tready;
    prev_addr    = m_req_taddr;
    if (m_req_tvalid && m_req_tready) begin
      req_seen++;
      if (exp_addr_q.size() == 0) check("req_extra", exp_addr_q.size(), 1);
      else check("req_addr", m_req_taddr, exp_addr_q.pop_front());
      rsp_q.push_back(m_req_taddr);
    end
    if (s_rsp_tvalid && s_rsp_tready) begin
      void'(rsp_q.pop_front());
      if (hold_rsp && rsp_credit > 0) rsp_credit--;
    end
    if (m_frag_tvalid && m_frag_tready) begin
      pix_seen++;
      if (sb_q.size() == 0) check("pix_extra", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        check("pix_data", m_frag_tdata, e.data);
        check("pix_x", m_frag_txpos, e.x);
        check("pix_y", m_frag_typos, e.y);
        check("pix_last", m_frag_tlast, e.last);
      end
    end
  endtask

  task automatic do_apply(input logic [AW-1:0] base, input int xr, input int yr,
                          input bit accept);
    confBaseAddr    = base;
    confXResolution = XW'(xr);
    confYResolution = YW'(yr);
    apply_pend      = 1;
    if (accept) begin
      req_seen = 0;
      pix_seen = 0;
      for (int i = 0; i < xr * yr; i++) begin
        pix_t p;
        logic [AW-1:0] a;
        a = base + AW'(i * (PW / 8));
        p.data = mem_rd(a);
        p.x    = XW'(i % xr);
        p.y    = YW'(i / xr);
        p.last = (i == xr * yr - 1);
        exp_addr_q.push_back(a);
        sb_q.push_back(p);
      end
    end
    step();
    step();
    if (accept) check("applied_busy", applied, 1'b0);
    // Config changes after capture must not disturb the frame.
    confBaseAddr    = AW'($urandom);
    confXResolution = XW'($urandom);
    confYResolution = YW'($urandom);
  endtask

  task automatic run_frame(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("frame_timeout", sb_q.size(), 0);
    step();
    check("applied_done", applied, 1'b1);
    check("addr_left", exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_applied"}, applied, 1'b1);
    check({tag, "_req_valid"}, m_req_tvalid, 1'b0);
    check({tag, "_frag_valid"}, m_frag_tvalid, 1'b0);
    check({tag, "_rsp_ready"}, s_rsp_tready, 1'b0);
    check({tag, "_taddr"}, m_req_taddr, '0);
    check({tag, "_xpos"}, m_frag_txpos, '0);
    check({tag, "_ypos"}, m_frag_typos, '0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs("rst");
    @(negedge aclk);
    resetn = 1'b1;

    // Basic 4x2 frame, latency-1 memory.
    do_apply(32'h1000, 4, 2, 1);
    run_frame(200);
    check("f1_reqs", req_seen, 8);
    check("f1_pix", pix_seen, 8);

    // Outstanding limit with responses withheld.
    hold_rsp   = 1;
    rsp_credit = 0;
    do_apply(32'h2000, 32, 1, 1);
    repeat (30) step();
    check("lim_reqs", req_seen, MO);
    check("lim_valid", m_req_tvalid, 1'b0);
    rsp_credit = 1;
    repeat (10) step();
    check("lim_reqs_plus1", req_seen, MO + 1);
    check("lim_valid2", m_req_tvalid, 1'b0);
    hold_rsp = 0;
    run_frame(400);
    check("lim_total", req_seen, 32);

    // Random stalls on both sides, 16x16.
    stall_req  = 1;
    stall_frag = 1;
    do_apply(32'h0004_0000, 16, 16, 1);
    run_frame(5000);
    check("st_reqs", req_seen, 256);
    check("st_pix", pix_seen, 256);
    stall_req  = 0;
    stall_frag = 0;

    // Empty frame is a no-op; apply during a frame is ignored.
    req_seen = 0;
    pix_seen = 0;
    do_apply(32'h3000, 0, 5, 0);
    repeat (5) step();
    check("zero_applied", applied, 1'b1);
    check("zero_reqs", req_seen, 0);
    do_apply(32'h5000, 8, 2, 1);
    repeat (3) step();
    do_apply(32'h9000, 2, 2, 0);
    run_frame(400);
    check("ign_reqs", req_seen, 16);
    check("ign_pix", pix_seen, 16);

    // Asynchronous reset in the middle of a 64x4 frame.
    do_apply(32'h8000, 64, 4, 1);
    n = 0;
    while (pix_seen < 10 && n < 500) begin
      step();
      n++;
    end
    check("mid_pix", pix_seen, 10);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    sb_q.delete();
    exp_addr_q.delete();
    rsp_q.delete();
    prev_stalled  = 0;
    s_rsp_tvalid  = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    do_apply(32'h8000, 3, 2, 1);
    run_frame(200);
    check("rr_reqs", req_seen, 6);
    check("rr_pix", pix_seen, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
